// File: rtl/vga_pkg.sv
// Shared VGA constants: display geometry, 2-bit-per-channel colours, direction encoding.
package vga_pkg;

    localparam int unsigned H_DISPLAY = 640;
    localparam int unsigned V_DISPLAY = 480;

    // Colours packed as {r[1:0], g[1:0], b[1:0]}
    typedef logic [5:0] rgb_t;

    localparam rgb_t RGB_BLACK = 6'b00_00_00;
    localparam rgb_t RGB_WHITE = 6'b11_11_11;
    localparam rgb_t RGB_BG    = 6'b00_00_01;
    localparam rgb_t PAL_0     = 6'b11_00_00;
    localparam rgb_t PAL_1     = 6'b00_11_00;
    localparam rgb_t PAL_2     = 6'b11_11_00;
    localparam rgb_t PAL_3     = 6'b11_00_11;

    typedef enum logic {
        DIR_POS = 1'b0,
        DIR_NEG = 1'b1
    } dir_e;

    typedef enum logic {
        StRun,
        StFlash
    } flash_state_e;

    function automatic rgb_t palette(input logic [1:0] idx);
        rgb_t c;
        unique case (idx)
            2'd0: c = PAL_0;
            2'd1: c = PAL_1;
            2'd2: c = PAL_2;
            2'd3: c = PAL_3;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/bounce_axis.sv
// One axis of the bouncing box: position, direction and an edge-hit flag.
module bounce_axis
    import vga_pkg::*;
#(
    parameter int unsigned LIMIT = 608,
    parameter int unsigned INIT  = 100,
    parameter int unsigned STEP  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic [9:0] pos,
    output logic       hit
);

    dir_e        dir;
    dir_e        dir_d;
    logic [9:0]  pos_d;
    logic [10:0] pos_sum;

    // 11-bit sum so the right/bottom limit test cannot wrap
    assign pos_sum = {1'b0, pos} + 11'(STEP);

    // Next position/direction; hit pulses only when an enabled step reaches an edge
    always_comb begin
        pos_d = pos;
        dir_d = dir;
        hit   = 1'b0;
        if (en) begin
            if (dir == DIR_POS) begin
                if (pos_sum >= 11'(LIMIT)) begin
                    pos_d = 10'(LIMIT);
                    dir_d = DIR_NEG;
                    hit   = 1'b1;
                end else begin
                    pos_d = pos_sum[9:0];
                end
            end else begin
                if (pos <= 10'(STEP)) begin
                    pos_d = 10'd0;
                    dir_d = DIR_POS;
                    hit   = 1'b1;
                end else begin
                    pos_d = pos - 10'(STEP);
                end
            end
        end
    end

    // Position and direction state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos <= 10'(INIT);
            dir <= DIR_POS;
        end else begin
            pos <= pos_d;
            dir <= dir_d;
        end
    end

endmodule

// File: rtl/bounce_renderer.sv
// Pixel stage after the VGA timing generator: draws a bouncing box, flashes on bounces,
// and re-aligns syncs so colour and sync leave on the same cycle.
module bounce_renderer
    import vga_pkg::*;
#(
    parameter int unsigned BOX_SIZE     = 32,
    parameter int unsigned STEP         = 2,
    parameter int unsigned INIT_X       = 100,
    parameter int unsigned INIT_Y       = 80,
    parameter int unsigned FLASH_FRAMES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pause,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic       active,
    input  logic       hsync_in,
    input  logic       vsync_in,
    output logic [1:0] r,
    output logic [1:0] g,
    output logic [1:0] b,
    output logic       hsync_out,
    output logic       vsync_out,
    output logic [7:0] bounce_count
);

    localparam int unsigned XMAX = H_DISPLAY - BOX_SIZE;
    localparam int unsigned YMAX = V_DISPLAY - BOX_SIZE;
    localparam int unsigned FW   = $clog2(FLASH_FRAMES + 1);

    logic              upd;
    logic              move_en;
    logic              hit_x;
    logic              hit_y;
    logic              hit;
    logic [9:0]        box_x;
    logic [9:0]        box_y;
    logic [1:0]        colour_idx;
    logic [FW-1:0]     flash_cnt;
    flash_state_e      state;
    logic              in_box;
    rgb_t              pix_d;

    // First blanking line: the box only moves while nothing visible is drawn
    assign upd     = (x == 10'd0) && (y == 10'(V_DISPLAY));
    assign move_en = upd && !pause;
    assign hit     = hit_x | hit_y;

    bounce_axis #(
        .LIMIT (XMAX),
        .INIT  (INIT_X),
        .STEP  (STEP)
    ) u_axis_x (
        .clk (clk),
        .rst (rst),
        .en  (move_en),
        .pos (box_x),
        .hit (hit_x)
    );

    bounce_axis #(
        .LIMIT (YMAX),
        .INIT  (INIT_Y),
        .STEP  (STEP)
    ) u_axis_y (
        .clk (clk),
        .rst (rst),
        .en  (move_en),
        .pos (box_y),
        .hit (hit_y)
    );

    // Flash FSM plus bounce bookkeeping; flash keeps counting down even while paused
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= StRun;
            flash_cnt    <= '0;
            colour_idx   <= 2'd0;
            bounce_count <= 8'd0;
        end else if (upd) begin
            if (hit) begin
                state        <= StFlash;
                flash_cnt    <= FW'(FLASH_FRAMES);
                colour_idx   <= colour_idx + 2'd1;
                bounce_count <= bounce_count + 8'd1;
            end else if (flash_cnt != '0) begin
                flash_cnt <= flash_cnt - FW'(1);
                if (flash_cnt == FW'(1)) begin
                    state <= StRun;
                end
            end
        end
    end

    // Box hit test on 11-bit sums so box edge + size never wraps
    assign in_box = ({1'b0, x} >= {1'b0, box_x}) &&
                    ({1'b0, x} <  ({1'b0, box_x} + 11'(BOX_SIZE))) &&
                    ({1'b0, y} >= {1'b0, box_y}) &&
                    ({1'b0, y} <  ({1'b0, box_y} + 11'(BOX_SIZE)));

    // Per-pixel colour selection
    always_comb begin
        pix_d = RGB_BG;
        if (!active) begin
            pix_d = RGB_BLACK;
        end else if (in_box) begin
            pix_d = (state == StFlash) ? RGB_WHITE : palette(colour_idx);
        end
    end

    // Output registers: colour and syncs share one cycle of latency
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {r, g, b} <= RGB_BLACK;
            hsync_out <= 1'b1;
            vsync_out <= 1'b1;
        end else begin
            {r, g, b} <= pix_d;
            hsync_out <= hsync_in;
            vsync_out <= vsync_in;
        end
    end

endmodule
